// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared state encoding and depth for the skid pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/en_reg_arn.sv
`default_nettype none
// ============================================================================
// Module   : en_reg_arn
// Brief    : Enabled data register, async active-low reset, sync clear.
// Revision : 1.0 - initial release
// ============================================================================
module en_reg_arn #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Clear wins over enable so a squash can never be overwritten by a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RST_VAL;
    end else if (i_clr) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/skid_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : skid_pipe_reg
// Brief    : Two-entry valid/ready pipeline register with skid slot and flush.
// Revision : 1.0 - initial release
// ============================================================================
module skid_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  pipe_state_e      r_state;
  pipe_state_e      w_next_state;
  logic             r_main_v;
  logic             r_skid_v;
  logic [1:0]       r_count;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_en;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_in_fire  = in_valid & ~r_skid_v;
  assign w_out_fire = r_main_v & out_ready;

  always_comb begin
    w_next_state = r_state;
    w_main_en    = 1'b0;
    w_skid_en    = 1'b0;
    w_main_d     = in_data;
    case (r_state)
      EMPTY: begin
        w_main_en = w_in_fire;
        if (w_in_fire) w_next_state = ONE;
      end
      ONE: begin
        w_main_en = w_in_fire & w_out_fire;
        w_skid_en = w_in_fire & ~w_out_fire;
        if (w_in_fire && !w_out_fire)      w_next_state = TWO;
        else if (!w_in_fire && w_out_fire) w_next_state = EMPTY;
      end
      TWO: begin
        w_main_en = w_out_fire;
        w_main_d  = w_skid_q;
        if (w_out_fire) w_next_state = ONE;
      end
      default: w_next_state = EMPTY;
    endcase
    if (flush) w_next_state = EMPTY;
  end

  // Flags are decoded from the next state so every output leaves a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      r_state  <= w_next_state;
      r_main_v <= (w_next_state != EMPTY);
      r_skid_v <= (w_next_state == TWO);
      case (w_next_state)
        ONE:     r_count <= 2'd1;
        TWO:     r_count <= 2'(PIPE_DEPTH);
        default: r_count <= 2'd0;
      endcase
    end
  end

  en_reg_arn #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_main_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_main_en),
    .i_clr (flush),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  en_reg_arn #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_skid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_skid_en),
    .i_clr (flush),
    .i_d   (in_data),
    .o_q   (w_skid_q)
  );

  assign in_ready  = ~r_skid_v;
  assign out_valid = r_main_v;
  assign out_data  = w_main_q;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_skid_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_skid_pipe_reg
// Brief    : Self-checking bench: vector table, corner sequences, random model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skid_pipe_reg;

  localparam int unsigned      WIDTH   = 32;
  localparam logic [WIDTH-1:0] RST_VAL = 32'h5A5A_00C3;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             flush     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  skid_pipe_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  typedef struct packed {
    logic        fl;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic f, input logic iv, input logic [31:0] d, input logic ordy);
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic ir, input logic ov,
                          input logic [31:0] od, input logic [1:0] cnt);
    chk({tag, "_in_ready"},  32'(in_ready),  32'(ir));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, "_out_data"},  out_data,       od);
    chk({tag, "_count"},     32'(count),     32'(cnt));
  endtask

  vec_t vecs[13];

  logic [31:0] q[$];
  logic [31:0] stale;
  logic [31:0] exp_od;
  logic        f, iv, ordy, ifire, ofire;
  logic [31:0] d;

  initial begin
    // Stall/skid, then flush-while-TWO, flush-while-EMPTY and flush-while-ONE.
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_000A, 1'b0, 1'b1, 1'b1, 32'h0000_000A, 2'd1};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_000B, 1'b0, 1'b0, 1'b1, 32'h0000_000A, 2'd2};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b1, 32'h0000_000A, 2'd2};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_000C, 1'b1, 1'b1, 1'b1, 32'h0000_000B, 2'd1};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_000C, 1'b1, 1'b1, 1'b1, 32'h0000_000C, 2'd1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_000C, 2'd0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h0000_0001, 2'd1};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 2'd2};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_DEAD, 1'b1, 1'b1, 1'b0, RST_VAL,       2'd0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, RST_VAL,       2'd0};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_DEAD, 1'b0, 1'b1, 1'b0, RST_VAL,       2'd0};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0005, 1'b1, 1'b1, 1'b1, 32'h0000_0005, 2'd1};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, RST_VAL,       2'd0};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 1'b1, 1'b0, RST_VAL, 2'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      tick();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_cnt);
    end

    // Back-to-back streaming: each beat visible one cycle after acceptance.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b1, 32'(i), 1'b1);
      tick();
      chk_outs($sformatf("stream%0d", i), 1'b1, 1'b1, 32'(i), 2'd1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk_outs("stream_drain", 1'b1, 1'b0, 32'h10, 2'd0);

    // Asynchronous reset with two entries held, observed before any edge.
    drive(1'b0, 1'b1, 32'h77, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h88, 1'b0);
    tick();
    chk("pre_reset_count", 32'(count), 32'd2);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("async_reset", 1'b1, 1'b0, RST_VAL, 2'd0);
    #2 rst_n = 1'b1;
    tick();
    chk_outs("post_reset", 1'b1, 1'b0, RST_VAL, 2'd0);

    // Random traffic against a queue model of the in-flight beats.
    q.delete();
    stale = RST_VAL;
    for (int n = 0; n < 10000; n++) begin
      f    = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 9) < 6);
      ordy = ($urandom_range(0, 9) < 6);
      d    = $urandom;
      drive(f, iv, d, ordy);
      if (f) begin
        q.delete();
        stale = RST_VAL;
      end else begin
        ifire = iv && (q.size() < 2);
        ofire = (q.size() > 0) && ordy;
        if (ofire) stale = q.pop_front();
        if (ifire) q.push_back(d);
      end
      exp_od = (q.size() > 0) ? q[0] : stale;
      tick();
      chk("rnd_in_ready",  32'(in_ready),  32'(q.size() < 2));
      chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("rnd_out_data",  out_data,       exp_od);
      chk("rnd_count",     32'(count),     32'(q.size()));
      chk("rnd_count_le2", 32'(count <= 2'd2), 32'd1);
      chk("rnd_skid_implies_main", 32'(dut.r_skid_v & ~dut.r_main_v), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
